bcd_digit_entry: RTL and testbench
==================================

// Module: bcd_digit_entry
// PURPOSE
//   Inverse of the binary-to-4-digit display path. It accepts decimal digits one at a time,
//   most significant digit first, for example from a keypad or a push-button digit selector.
//   Each accepted digit is accumulated as acc = acc*10 + digit.
//   On enter, the result is committed as a binary value, e.g. as a preload for the counter.
//   While digits are being entered, the live accumulator can drive the BCD display decoder.
// PARAMETERS
//   N_OUT  10  width of committed binary result value_out (max 2^N_OUT-1)
//   N_DIG  4   maximum number of digits accepted per entry (1..4)
//   ACC_W  14  accumulator width; must hold 10^N_DIG-1 (9999 -> 14 bits)
// PORTS
//   clk          in   1      single system clock, rising edge
//   rst          in   1      asynchronous reset, active-high
//   digit_in     in   4      BCD digit, valid 0..9
//   digit_valid  in   1      1-cycle strobe: digit_in presented this cycle
//   enter        in   1      1-cycle strobe: commit current entry
//   clear        in   1      1-cycle strobe: abort/erase entry and result
//   acc_out      out  ACC_W  live accumulator (decimal value typed so far)
//   digit_count  out  3      digits accepted in current entry, 0..N_DIG
//   value_out    out  N_OUT  committed binary result, saturated
//   value_valid  out  1      high while value_out holds a committed result
//   overflow     out  1      committed result exceeded 2^N_OUT-1 (value_out saturated)
//   err_digit    out  1      1-cycle pulse: a strobed digit was rejected
// BEHAVIOUR
//   Reset (rst=1, async): state=IDLE; all outputs 0 (acc_out, digit_count, value_out,
//     value_valid, overflow, err_digit).
//   All outputs registered. Input strobes are sampled at the rising edge.
//   Effects of a strobe appear on the outputs in the cycle after that edge (1-cycle latency).
//   Priority when strobes coincide: clear > enter > digit_valid.
//     A digit strobed in the same cycle as enter or clear is dropped silently (no err_digit).
//   FSM states: IDLE (no digits), ENTRY (1..N_DIG digits held), DONE (result committed).
//   IDLE:
//     digit_valid and digit_in<=9 -> acc=digit_in, count=1, go to ENTRY.
//     enter -> ignored; stay in IDLE.
//   ENTRY:
//     digit_valid, digit_in<=9, count<N_DIG -> acc=acc*10+digit_in, count+1.
//     enter -> go to DONE.
//       value_out = (acc > 2^N_OUT-1) ? {N_OUT{1'b1}} : acc[N_OUT-1:0].
//       overflow = (acc > 2^N_OUT-1).
//       value_valid = 1.
//       acc_out and digit_count are held.
//   DONE:
//     value_out, value_valid and overflow are held.
//     digit_valid with a legal digit -> start a new entry.
//       acc=digit_in, count=1, value_valid=0, overflow=0, go to ENTRY.
//       value_out keeps its old value but is invalid.
//     enter -> ignored; result is held.
//   Any state, clear: go to IDLE; acc, count, value_out, value_valid, overflow all 0.
//   Rejection:
//     digit_in>9 with digit_valid, in any state -> err_digit=1 for one cycle; no other change.
//     digit_valid in ENTRY with count==N_DIG -> err_digit=1; digit not accepted.
//   Arithmetic:
//     acc*10 is computed as (acc<<3)+(acc<<1) at ACC_W bits.
//     acc never exceeds 10^N_DIG-1, so no internal wrap.
//   Leading zeros are accepted and count as digits ("0","0","7" gives 7, count=3).
//   Reset mid-entry: async rst aborts immediately; all outputs are 0 before the next edge.
// TESTING
//   Digits 1,2,3 then enter -> acc_out=123, count=3; then value_out=123, value_valid=1, overflow=0.
//   Digits 9,9,9,9, enter (N_OUT=10) -> acc_out=9999; value_out=1023, overflow=1, value_valid=1.
//   digit_in=12 strobed -> err_digit=1 for exactly 1 cycle; acc_out and count unchanged.
//   Fifth digit after 4 accepted -> err_digit=1, acc_out unchanged; then enter commits the 4-digit value.
//   Same cycle digit_valid(5), enter and clear -> IDLE, all outputs 0, err_digit=0.
//   In DONE (value 42), strobe digit 7 -> value_valid=0, acc_out=7, count=1.
//   Assert rst async mid-entry -> outputs 0 immediately, before the next clk edge.
//   enter in IDLE -> no change (value_valid stays 0).

Source files
------------

// File: rtl/bcd_digit_entry.sv
// bcd_digit_entry: accumulates decimal digits MSD-first and commits them as a saturated binary value.
module bcd_digit_entry #(
    parameter int N_OUT = 10,
    parameter int N_DIG = 4,
    parameter int ACC_W = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       digit_in,
    input  logic             digit_valid,
    input  logic             enter,
    input  logic             clear,
    output logic [ACC_W-1:0] acc_out,
    output logic [2:0]       digit_count,
    output logic [N_OUT-1:0] value_out,
    output logic             value_valid,
    output logic             overflow,
    output logic             err_digit
);
    typedef enum logic [1:0] {IDLE, ENTRY, DONE} state_t;

    state_t           state, state_n;
    logic [ACC_W-1:0] acc_n;
    logic [2:0]       cnt_n;
    logic [N_OUT-1:0] val_n;
    logic             vv_n, ovf_n, err_n;
    logic             big, full, legal;

    assign legal = digit_in <= 4'd9;
    assign full  = digit_count >= 3'(N_DIG);
    assign big   = acc_out > ACC_W'(2 ** N_OUT - 1);

    always_comb begin
        state_n = state;
        acc_n   = acc_out;
        cnt_n   = digit_count;
        val_n   = value_out;
        vv_n    = value_valid;
        ovf_n   = overflow;
        err_n   = 1'b0;
        if (clear) begin
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
            val_n   = '0;
            vv_n    = 1'b0;
            ovf_n   = 1'b0;
        end else if (enter) begin
            if (state == ENTRY) begin
                state_n = DONE;
                vv_n    = 1'b1;
                ovf_n   = big;
                val_n   = big ? '1 : acc_out[N_OUT-1:0];
            end
        end else if (digit_valid) begin
            if (!legal || (state == ENTRY && full)) begin
                err_n = 1'b1;
            end else if (state == ENTRY) begin
                // acc*10 as shift-add; acc is bounded by 10^N_DIG-1 so it never wraps
                acc_n = (acc_out << 3) + (acc_out << 1) + ACC_W'(digit_in);
                cnt_n = digit_count + 3'd1;
            end else begin
                state_n = ENTRY;
                acc_n   = ACC_W'(digit_in);
                cnt_n   = 3'd1;
                vv_n    = 1'b0;
                ovf_n   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc_out     <= '0;
            digit_count <= '0;
            value_out   <= '0;
            value_valid <= 1'b0;
            overflow    <= 1'b0;
            err_digit   <= 1'b0;
        end else begin
            state       <= state_n;
            acc_out     <= acc_n;
            digit_count <= cnt_n;
            value_out   <= val_n;
            value_valid <= vv_n;
            overflow    <= ovf_n;
            err_digit   <= err_n;
        end
    end
endmodule

// File: tb/tb_bcd_digit_entry.sv
// tb_bcd_digit_entry: directed vector table, async-reset check, and random run against a digit-list model.
module tb_bcd_digit_entry;
    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  digit_in = '0;
    logic        digit_valid = 1'b0, enter = 1'b0, clear = 1'b0;
    logic [13:0] acc_out;
    logic [2:0]  digit_count;
    logic [9:0]  value_out;
    logic        value_valid, overflow, err_digit;

    int n_checks = 0, n_fail = 0;

    bcd_digit_entry dut (
        .clk(clk), .rst(rst), .digit_in(digit_in), .digit_valid(digit_valid),
        .enter(enter), .clear(clear), .acc_out(acc_out), .digit_count(digit_count),
        .value_out(value_out), .value_valid(value_valid), .overflow(overflow),
        .err_digit(err_digit)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d; bit dv, en, cl;
        int acc, cnt, val; bit vv, ovf, err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int d, bit dv, bit en, bit cl, int acc, int cnt, int val, bit vv, bit ovf, bit err);
        vec_t v;
        v.d = d; v.dv = dv; v.en = en; v.cl = cl;
        v.acc = acc; v.cnt = cnt; v.val = val; v.vv = vv; v.ovf = ovf; v.err = err;
        return v;
    endfunction

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(string tag, int acc, int cnt, int val, bit vv, bit ovf, bit err);
        check({tag, " acc_out"}, int'(acc_out), acc);
        check({tag, " digit_count"}, int'(digit_count), cnt);
        check({tag, " value_out"}, int'(value_out), val);
        check({tag, " value_valid"}, int'(value_valid), int'(vv));
        check({tag, " overflow"}, int'(overflow), int'(ovf));
        check({tag, " err_digit"}, int'(err_digit), int'(err));
    endtask

    task automatic drive(int d, bit dv, bit en, bit cl);
        @(negedge clk);
        digit_in = 4'(d); digit_valid = dv; enter = en; clear = cl;
        @(posedge clk);
        #1;
    endtask

    // Reference model: the entry is just the list of digits typed so far plus a committed result.
    int  m_digits[$];
    int  m_val;
    bit  m_vv, m_ovf, m_done, m_err;

    function automatic int m_acc();
        int a = 0;
        foreach (m_digits[i]) a = a * 10 + m_digits[i];
        return a;
    endfunction

    function automatic void m_reset();
        m_digits.delete(); m_val = 0; m_vv = 0; m_ovf = 0; m_done = 0; m_err = 0;
    endfunction

    function automatic void m_step(int d, bit dv, bit en, bit cl);
        int a;
        m_err = 0;
        if (cl) m_reset();
        else if (en) begin
            if (m_digits.size() > 0 && !m_done) begin
                a = m_acc();
                m_ovf = a > 1023; m_val = m_ovf ? 1023 : a; m_vv = 1; m_done = 1;
            end
        end else if (dv) begin
            if (d > 9) m_err = 1;
            else if (m_done) begin
                m_digits.delete(); m_digits.push_back(d);
                m_vv = 0; m_ovf = 0; m_done = 0;
            end else if (m_digits.size() < 4) m_digits.push_back(d);
            else m_err = 1;
        end
    endfunction

    initial begin
        #2 check_all("reset", 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst = 1'b0;

        vecs.push_back(mk(1, 1,0,0,    1,1,   0,0,0,0));
        vecs.push_back(mk(2, 1,0,0,   12,2,   0,0,0,0));
        vecs.push_back(mk(3, 1,0,0,  123,3,   0,0,0,0));
        vecs.push_back(mk(0, 0,1,0,  123,3, 123,1,0,0));
        vecs.push_back(mk(0, 0,1,0,  123,3, 123,1,0,0));
        vecs.push_back(mk(12,1,0,0,  123,3, 123,1,0,1));
        vecs.push_back(mk(0, 0,0,0,  123,3, 123,1,0,0));
        vecs.push_back(mk(0, 0,0,1,    0,0,   0,0,0,0));
        vecs.push_back(mk(0, 0,1,0,    0,0,   0,0,0,0));
        vecs.push_back(mk(15,1,0,0,    0,0,   0,0,0,1));
        vecs.push_back(mk(9, 1,0,0,    9,1,   0,0,0,0));
        vecs.push_back(mk(9, 1,0,0,   99,2,   0,0,0,0));
        vecs.push_back(mk(9, 1,0,0,  999,3,   0,0,0,0));
        vecs.push_back(mk(9, 1,0,0, 9999,4,   0,0,0,0));
        vecs.push_back(mk(5, 1,0,0, 9999,4,   0,0,0,1));
        vecs.push_back(mk(0, 0,1,0, 9999,4,1023,1,1,0));
        vecs.push_back(mk(5, 1,1,1,    0,0,   0,0,0,0));
        vecs.push_back(mk(4, 1,0,0,    4,1,   0,0,0,0));
        vecs.push_back(mk(2, 1,0,0,   42,2,   0,0,0,0));
        vecs.push_back(mk(0, 0,1,0,   42,2,  42,1,0,0));
        vecs.push_back(mk(7, 1,0,0,    7,1,  42,0,0,0));
        vecs.push_back(mk(3, 1,1,0,    7,1,   7,1,0,0));
        vecs.push_back(mk(0, 0,0,1,    0,0,   0,0,0,0));
        vecs.push_back(mk(0, 1,0,0,    0,1,   0,0,0,0));
        vecs.push_back(mk(0, 1,0,0,    0,2,   0,0,0,0));
        vecs.push_back(mk(7, 1,0,0,    7,3,   0,0,0,0));
        vecs.push_back(mk(10,1,0,0,    7,3,   0,0,0,1));
        vecs.push_back(mk(0, 0,1,0,    7,3,   7,1,0,0));
        vecs.push_back(mk(8, 1,0,0,    8,1,   7,0,0,0));
        vecs.push_back(mk(6, 1,0,0,   86,2,   7,0,0,0));

        foreach (vecs[i]) begin
            drive(vecs[i].d, vecs[i].dv, vecs[i].en, vecs[i].cl);
            check_all($sformatf("vec%0d", i), vecs[i].acc, vecs[i].cnt, vecs[i].val,
                      vecs[i].vv, vecs[i].ovf, vecs[i].err);
        end

        // async reset mid-entry must clear outputs before the next rising edge
        drive(0, 0, 1, 0);
        drive(5, 1, 0, 0);
        check("pre-rst acc_out", int'(acc_out), 5);
        @(negedge clk);
        digit_valid = 1'b0; enter = 1'b0;
        #1 rst = 1'b1;
        #1 check_all("async rst", 0, 0, 0, 0, 0, 0);
        @(negedge clk) rst = 1'b0;
        m_reset();

        for (int c = 0; c < 3000; c++) begin
            int d; bit dv, en, cl;
            d  = $urandom_range(0, 11);
            dv = ($urandom_range(0, 99) < 60);
            en = ($urandom_range(0, 99) < 12);
            cl = ($urandom_range(0, 99) < 3);
            drive(d, dv, en, cl);
            m_step(d, dv, en, cl);
            check_all($sformatf("rand%0d", c), m_acc(), m_digits.size(), m_val, m_vv, m_ovf, m_err);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
